// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter and access sequencer for a single-ported byte-addressed data memory
module dmem_arbiter #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req0_valid,
    input  logic        i_req0_we,
    input  logic [31:0] i_req0_addr,
    input  logic [31:0] i_req0_wdata,
    input  logic        i_req1_valid,
    input  logic        i_req1_we,
    input  logic [31:0] i_req1_addr,
    input  logic [31:0] i_req1_wdata,
    output logic        o_req0_ready,
    output logic        o_req1_ready,
    output logic        o_resp0_valid,
    output logic        o_resp0_err,
    output logic [31:0] o_resp0_rdata,
    output logic        o_resp1_valid,
    output logic        o_resp1_err,
    output logic [31:0] o_resp1_rdata,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_we,
    output logic        o_mem_re,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t      r_state;
    logic        r_last, r_port, r_we, r_oor;
    logic        w_idle, w_any, w_gnt, w_we, w_oor, w_rsp, w_rsp_err;
    logic [31:0] w_addr, w_wdata, w_rsp_data;
    always_comb begin
        w_idle     = r_state == IDLE;
        w_any      = i_req0_valid | i_req1_valid;
        w_gnt      = (i_req0_valid & i_req1_valid) ? ~r_last : i_req1_valid;
        w_we       = w_gnt ? i_req1_we : i_req0_we;
        w_addr     = w_gnt ? i_req1_addr : i_req0_addr;
        w_wdata    = w_gnt ? i_req1_wdata : i_req0_wdata;
        w_oor      = ({1'b0, w_addr} + 33'd3) >= 33'(MEM_BYTES);
        // a response leaves on this edge: write/oor from ISSUE, read data from WAIT
        w_rsp      = (r_state == ISSUE & (r_we | r_oor)) | (r_state == WAIT);
        w_rsp_err  = r_state == ISSUE & r_oor;
        w_rsp_data = r_state == WAIT ? i_mem_rdata : 32'h0;
    end
    assign o_req0_ready = rst_n & w_idle & i_req0_valid & ~w_gnt;
    assign o_req1_ready = rst_n & w_idle & i_req1_valid & w_gnt;
    assign o_busy       = ~w_idle;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_last        <= 1'b1;
            r_port        <= 1'b0;
            r_we          <= 1'b0;
            r_oor         <= 1'b0;
            o_mem_addr    <= 32'h0;
            o_mem_wdata   <= 32'h0;
            o_mem_we      <= 1'b0;
            o_mem_re      <= 1'b0;
            o_resp0_valid <= 1'b0;
            o_resp0_err   <= 1'b0;
            o_resp0_rdata <= 32'h0;
            o_resp1_valid <= 1'b0;
            o_resp1_err   <= 1'b0;
            o_resp1_rdata <= 32'h0;
        end else begin
            o_resp0_valid <= w_rsp & ~r_port;
            o_resp1_valid <= w_rsp & r_port;
            if (w_rsp & ~r_port) begin
                o_resp0_err   <= w_rsp_err;
                o_resp0_rdata <= w_rsp_data;
            end
            if (w_rsp & r_port) begin
                o_resp1_err   <= w_rsp_err;
                o_resp1_rdata <= w_rsp_data;
            end
            case (r_state)
                IDLE: if (w_any) begin
                    r_port      <= w_gnt;
                    r_last      <= w_gnt;
                    r_we        <= w_we;
                    r_oor       <= w_oor;
                    o_mem_addr  <= w_addr;
                    o_mem_wdata <= w_wdata;
                    o_mem_we    <= w_we & ~w_oor;
                    o_mem_re    <= ~w_we & ~w_oor;
                    r_state     <= ISSUE;
                end
                ISSUE: begin
                    o_mem_we <= 1'b0;
                    o_mem_re <= 1'b0;
                    r_state  <= (r_we | r_oor) ? IDLE : WAIT;
                end
                WAIT:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table, hand-written and random checks of dmem_arbiter against a cycle scoreboard
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n, clr;
    logic        v0, we0, v1, we1;
    logic [31:0] a0, d0, a1, d1;
    logic        ready0, ready1, rv0, rv1, err0, err1, mem_we, mem_re, busy;
    logic [31:0] rd0, rd1, mem_addr, mem_wdata, mem_rdata;
    int          n_chk = 0, n_fail = 0, cyc = 0;
    int          rvcnt[2];
    bit          gq[$];
    int          hq[$];
    logic [7:0]  dev[1024];
    logic [7:0]  ref_mem[1024];

    typedef struct {
        bit p; bit we; logic [31:0] a; logic [31:0] d; bit err; logic [31:0] rd; int lat;
    } vec_t;
    typedef struct {
        bit act; bit p; bit we; bit oor; logic [31:0] a; logic [31:0] d; logic [31:0] rd; int hs;
    } fl_t;
    fl_t f;
    bit  mlast;
    int  m_rc, m_a;
    bit  m_idle, m_g, m_sw, m_sr, m_e0, m_e1, m_busy;

    dmem_arbiter #(.MEM_BYTES(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req0_valid(v0), .i_req0_we(we0), .i_req0_addr(a0), .i_req0_wdata(d0),
        .i_req1_valid(v1), .i_req1_we(we1), .i_req1_addr(a1), .i_req1_wdata(d1),
        .o_req0_ready(ready0), .o_req1_ready(ready1),
        .o_resp0_valid(rv0), .o_resp0_err(err0), .o_resp0_rdata(rd0),
        .o_resp1_valid(rv1), .o_resp1_err(err1), .o_resp1_rdata(rd1),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we), .o_mem_re(mem_re),
        .i_mem_rdata(mem_rdata), .o_busy(busy)
    );

    always #5 clk = ~clk;

    // memory device: write on the strobe edge, read data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) dev[i] <= 8'h0;
            mem_rdata <= 32'h0;
        end else begin
            if (mem_we && mem_addr < 32'd1021) begin
                dev[mem_addr[9:0]]         <= mem_wdata[7:0];
                dev[mem_addr[9:0] + 10'd1] <= mem_wdata[15:8];
                dev[mem_addr[9:0] + 10'd2] <= mem_wdata[23:16];
                dev[mem_addr[9:0] + 10'd3] <= mem_wdata[31:24];
            end
            if (mem_re && mem_addr < 32'd1021)
                mem_rdata <= {dev[mem_addr[9:0] + 10'd3], dev[mem_addr[9:0] + 10'd2],
                              dev[mem_addr[9:0] + 10'd1], dev[mem_addr[9:0]]};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // scoreboard: one request in flight; strobe one cycle after accept, response 2 (write/oor) or 3 (read) after
    always @(negedge clk) begin
        cyc++;
        if (clr) for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h0;
        if (!rst_n) begin
            chk("rst_ctl", {ready0, ready1, rv0, rv1, err0, err1, mem_we, mem_re, busy}, 0);
            chk("rst_data", rd0 | rd1 | mem_addr | mem_wdata, 0);
            f.act = 0;
            mlast = 1;
        end else begin
            m_rc   = f.act ? f.hs + ((f.we || f.oor) ? 2 : 3) : -1;
            m_sw   = f.act && cyc == f.hs + 1 && !f.oor && f.we;
            m_sr   = f.act && cyc == f.hs + 1 && !f.oor && !f.we;
            m_e0   = f.act && cyc == m_rc && !f.p;
            m_e1   = f.act && cyc == m_rc && f.p;
            m_busy = f.act && cyc > f.hs && cyc < m_rc;
            chk("mem_we", mem_we, m_sw);
            chk("mem_re", mem_re, m_sr);
            if (m_sw || m_sr) chk("mem_addr", mem_addr, f.a);
            if (m_sw) chk("mem_wdata", mem_wdata, f.d);
            chk("busy", busy, m_busy);
            chk("resp0_valid", rv0, m_e0);
            chk("resp1_valid", rv1, m_e1);
            if (m_e0) begin chk("resp0_err", err0, f.oor); chk("resp0_rdata", rd0, f.rd); end
            if (m_e1) begin chk("resp1_err", err1, f.oor); chk("resp1_rdata", rd1, f.rd); end
            if (rv0) rvcnt[0]++;
            if (rv1) rvcnt[1]++;
            m_idle = !f.act || cyc == m_rc;
            if (m_idle) f.act = 0;
            m_g = (v0 && v1) ? !mlast : v1;
            chk("ready0", ready0, m_idle && v0 && !m_g);
            chk("ready1", ready1, m_idle && v1 && m_g);
            if (m_idle && (v0 || v1)) begin
                f.act = 1;
                f.p   = m_g;
                f.we  = m_g ? we1 : we0;
                f.a   = m_g ? a1 : a0;
                f.d   = m_g ? d1 : d0;
                f.hs  = cyc;
                f.oor = longint'(f.a) + 3 >= 1024;
                m_a   = int'(f.a[9:0]);
                f.rd  = (f.we || f.oor) ? 32'h0 :
                        {ref_mem[m_a + 3], ref_mem[m_a + 2], ref_mem[m_a + 1], ref_mem[m_a]};
                if (f.we && !f.oor) for (int k = 0; k < 4; k++) ref_mem[m_a + k] = f.d[8 * k +: 8];
                mlast = m_g;
                gq.push_back(m_g);
                hq.push_back(cyc);
            end
        end
    end

    task automatic drv(input bit p, input bit v, input bit we, input logic [31:0] a, input logic [31:0] d);
        if (p) begin v1 = v; we1 = we; a1 = a; d1 = d; end
        else   begin v0 = v; we0 = we; a0 = a; d0 = d; end
    endtask

    // called #1 after a posedge; returns #1 after the accepting edge
    task automatic req(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        drv(p, 1, we, a, d);
        do begin @(negedge clk); n++; end while (!(p ? ready1 : ready0) && n < 40);
        if (n >= 40) begin
            n_chk++;
            n_fail++;
            $display("FAIL req_timeout: port %0d got no ready within 40 cycles", p);
        end
        @(posedge clk);
        #1 drv(p, 0, 0, 0, 0);
    endtask

    task automatic xfer(input vec_t v);
        int n = 0;
        req(v.p, v.we, v.a, v.d);
        do begin @(negedge clk); n++; end while (!(v.p ? rv1 : rv0) && n < 10);
        chk("xfer_latency", n, v.lat);
        chk("xfer_err", v.p ? err1 : err0, v.err);
        chk("xfer_rdata", v.p ? rd1 : rd0, v.rd);
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_port(input bit p, input int cnt);
        logic [31:0] a;
        for (int i = 0; i < cnt; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            case ($urandom_range(0, 3))
                0:       a = $urandom_range(0, 1020);
                1:       a = 32'd1017 + $urandom_range(0, 6);
                2:       a = $urandom;
                default: a = $urandom_range(0, 31) * 4;
            endcase
            req(p, $urandom_range(0, 1), a, $urandom);
        end
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{0, 1, 32'h10,       32'hDEADBEEF, 0, 32'h0,        2};
        tbl[1]  = '{0, 0, 32'h10,       32'h0,        0, 32'hDEADBEEF, 3};
        tbl[2]  = '{1, 0, 32'd1021,     32'h0,        1, 32'h0,        2};
        tbl[3]  = '{1, 0, 32'd1020,     32'h0,        0, 32'h0,        3};
        tbl[4]  = '{1, 1, 32'd1020,     32'h12345678, 0, 32'h0,        2};
        tbl[5]  = '{0, 0, 32'd1020,     32'h0,        0, 32'h12345678, 3};
        tbl[6]  = '{1, 1, 32'h13,       32'hA1B2C3D4, 0, 32'h0,        2};
        tbl[7]  = '{0, 0, 32'h10,       32'h0,        0, 32'hD4ADBEEF, 3};
        tbl[8]  = '{1, 0, 32'h14,       32'h0,        0, 32'h00A1B2C3, 3};
        tbl[9]  = '{0, 1, 32'hFFFFFFFE, 32'h55555555, 1, 32'h0,        2};
        tbl[10] = '{1, 0, 32'hFFFFFFFF, 32'h0,        1, 32'h0,        2};
        tbl[11] = '{0, 1, 32'd1021,     32'h66666666, 1, 32'h0,        2};
        rst_n = 1; clr = 1;
        drv(0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0);
        #2 rst_n = 0;
        repeat (2) @(posedge clk);
        #1 clr = 0; rst_n = 1;

        // contention from reset: port 0 first, port 1 waits for port 0's response cycle
        gq.delete(); hq.delete();
        fork
            req(0, 0, 32'h0, 32'h0);
            req(1, 0, 32'h4, 32'h0);
        join
        repeat (4) begin @(posedge clk); #1; end
        chk("cont_grants", gq.size(), 2);
        if (gq.size() == 2) begin
            chk("cont_first", gq[0], 0);
            chk("cont_second", gq[1], 1);
            chk("cont_gap", hq[1] - hq[0], 3);
        end

        foreach (tbl[i]) xfer(tbl[i]);

        // reset during WAIT drops the response; the next read completes normally
        req(0, 0, 32'h10, 32'h0);
        @(posedge clk);
        #1 chk("busy_in_wait", busy, 1);
        rst_n = 0;
        #1 chk("async_rst", {busy, mem_re, mem_we, rv0}, 0);
        @(posedge clk);
        #1 rst_n = 1;
        repeat (4) begin @(posedge clk); #1; end
        xfer('{0, 0, 32'h10, 32'h0, 0, 32'hD4ADBEEF, 3});

        // fairness and back-to-back: two write streams
        gq.delete(); hq.delete(); rvcnt = '{0, 0};
        fork
            begin for (int i = 0; i < 6; i++) req(0, 1, 32'h100 + 4 * i, $urandom); end
            begin for (int j = 0; j < 6; j++) req(1, 1, 32'h200 + 4 * j, $urandom); end
        join
        repeat (4) begin @(posedge clk); #1; end
        chk("fair_resp0", rvcnt[0], 6);
        chk("fair_resp1", rvcnt[1], 6);
        chk("fair_grants", gq.size(), 12);
        for (int i = 1; i < gq.size(); i++) begin
            chk("fair_alternate", gq[i], !gq[i - 1]);
            chk("b2b_gap", hq[i] - hq[i - 1], 2);
        end

        // random traffic on both ports
        rvcnt = '{0, 0};
        fork
            rnd_port(0, 40);
            rnd_port(1, 40);
        join
        repeat (5) begin @(posedge clk); #1; end
        chk("rand_resp0", rvcnt[0], 40);
        chk("rand_resp1", rvcnt[1], 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the byte-addressed, single-ported data memory. It lets two requesters share one memory: port 0 is the core load/store path and port 1 is the debug/loader path. It accepts requests on a valid/ready handshake, picks between the ports round-robin, and issues one memory strobe per request. It returns a one-cycle response pulse carrying the read data or a write acknowledge. Sits between the pipeline's memory stage and the data memory.

## Interface
- MEM_BYTES, 1024: memory size in bytes. A word access with Addr+3 >= MEM_BYTES is out of range.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- Req0Valid_i / Req1Valid_i  in  1  request present on port N.
- Req0We_i / Req1We_i  in  1  1 = write, 0 = read.
- Req0Addr_i / Req1Addr_i  in  32  byte address of the word; little-endian.
- Req0WData_i / Req1WData_i  in  32  write data.
- Req0Ready_o / Req1Ready_o  out  1  request accepted on this edge when Valid & Ready.
- Resp0Valid_o / Resp1Valid_o  out  1  one-cycle completion pulse.
- Resp0Err_o / Resp1Err_o  out  1  out-of-range flag; valid with RespValid.
- Resp0RData_o / Resp1RData_o  out  32  read data; valid with RespValid on reads, 0 on writes and errors.
- MemAddr_o  out  32  registered address to memory.
- MemWData_o  out  32  registered write data.
- MemWe_o  out  1  write strobe; memory writes on the posedge ending this cycle.
- MemRe_o  out  1  read strobe; memory presents MemRData_i in the following cycle.
- MemRData_i  in  32  read data from memory.
- Busy_o  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**
  - Choose the grant: if only one port is valid, grant it. If both are valid, grant the port that is not LastGrant.
  - Ready_o is high combinationally for the granted port only. Ready_o is never high outside IDLE.
  - On handshake: latch port id, we, addr, wdata and oor (addr+3 >= MEM_BYTES, computed as a 33-bit compare so wrap-around is not allowed). Update LastGrant to the granted port. Go to ISSUE.
- **ISSUE**
  - Drive MemAddr_o and MemWData_o from the latched values.
  - MemWe_o = we & ~oor. MemRe_o = ~we & ~oor.
  - Write or oor request: pulse RespValid for the latched port in the next cycle. Err = oor; RData = 0. Go to IDLE.
  - Read, in range: go to WAIT.
- **WAIT**
  - No strobes driven.
  - Capture MemRData_i into that port's RData register. Pulse RespValid with Err = 0 in the next cycle. Go to IDLE.
- RespValid/RData/Err are registered outputs. A RespValid pulse can coincide with a new handshake in IDLE.
- Only one request is in flight at a time, so there is no reordering.
- Memory strobes are asserted for exactly one cycle per in-range request and never for out-of-range requests.

## Timing
- Reset values:
  - state = IDLE; LastGrant = 1, so port 0 wins the first contention.
  - All Ready_o, RespValid, Err, MemWe_o, MemRe_o, Busy_o = 0.
  - All RData registers, MemAddr_o and MemWData_o = 0.
- Handshake in cycle 0 (edge E0):
  - ISSUE in cycle 1.
  - Write: memory written at E1; RespValid in cycle 2; next accept possible in cycle 2.
  - Read: WAIT in cycle 2; RespValid with data in cycle 3; next accept possible in cycle 3.
- Sustained throughput: one write per 2 cycles, one read per 3 cycles.
- Both ports continuously valid: grants alternate 0,1,0,1. A port is never granted twice in a row while the other port is waiting.
- Valid drops before handshake: no effect. Requesters hold Valid and payload until Ready.
- Reset asserted mid-operation (ISSUE/WAIT): FSM returns to IDLE immediately. Strobes deassert asynchronously. The pending response is dropped and no RespValid is issued after reset.

## Test plan
- Single write then read, port 0:
  - Write addr 0x10, data 0xDEADBEEF: MemWe_o=1 in cycle 1, Resp0Valid=1 Err=0 in cycle 2.
  - Read addr 0x10: MemRe_o=1 in cycle 1, Resp0Valid=1 with RData=0xDEADBEEF in cycle 3.
- Contention: both ports issue reads (0x0 / 0x4) from reset with both Valid held.
  - Grant order is port 0 then port 1. Port 1 Ready stays low until port 0's response cycle.
- Fairness: both ports stream 6 writes each.
  - Grants strictly alternate. Each port sees 6 RespValid pulses.
- Out of range: port 1 reads addr 1021.
  - No MemRe_o. Resp1Valid=1, Err=1, RData=0 in cycle 2.
  - Addr 1020 is in range: no Err.
- Reset mid-read: drop rst_n during WAIT.
  - Outputs return to reset values at once. No Resp pulse after rst_n rises.
  - The next request completes normally.
- Back-to-back: new handshake in the same cycle as the previous RespValid.
  - Accepted. Latencies match the Timing section.
